// File: rtl/uart_pkg.sv
// Shared constants and types for the UART baud-rate generator.
// Holds the default divisor set, the minimum accepted divisor and the tick bundle type.
package uart_pkg;

    localparam int DEF_DIV_WIDTH   = 16;
    localparam int DEF_DEFAULT_DIV = 1302;
    localparam int DEF_OS_LOG2     = 4;

    // Smallest divisor that still leaves at least two clocks per oversample period.
    function automatic int min_div(input int os_log2);
        return 32'sd2 << os_log2;
    endfunction

    localparam int MIN_DIV = min_div(DEF_OS_LOG2);

    typedef struct packed {
        logic tx;
        logic rx_os;
        logic rx_bit;
    } baud_tick_t;

endpackage

// File: rtl/baud_div_counter.sv
// Modulo-N counter producing a registered one-cycle tick on each wrap to zero.
// o_wrap flags, one cycle early, that the coming edge performs a counted wrap.
module baud_div_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_period,
    output logic             o_wrap,
    output logic             o_tick
);

    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             w_last;

    // >= rather than == keeps the counter bounded if the period ever shrinks under it.
    assign w_last = (r_count >= (i_period - WIDTH'(1'b1)));
    assign o_wrap = i_enable && !i_clear && w_last;
    assign o_tick = r_tick;

    // Count state: disable and clear both park the counter at zero without a tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (!i_enable || i_clear) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (w_last) begin
            r_count <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + WIDTH'(1'b1);
            r_tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable UART baud generator: TX bit tick plus RX oversample/bit ticks.
// Divisor changes are staged in a shadow register and applied only on a TX wrap.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
    parameter int DEFAULT_DIV = DEF_DEFAULT_DIV,
    parameter int OS_LOG2     = DEF_OS_LOG2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 rx_resync,
    output logic                 tx_tick,
    output logic                 rx_os_tick,
    output logic                 rx_bit_tick,
    output logic [OS_LOG2-1:0]   rx_os_idx,
    output logic [DIV_WIDTH-1:0] div_active,
    output logic                 div_pending,
    output logic                 div_err
);

    localparam logic [DIV_WIDTH-1:0] RST_DIV   = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(min_div(OS_LOG2));
    localparam logic [OS_LOG2-1:0]   IDX_MAX   = {OS_LOG2{1'b1}};

    logic [DIV_WIDTH-1:0] r_div_active;
    logic [DIV_WIDTH-1:0] r_rx_period;
    logic [DIV_WIDTH-1:0] r_shadow;
    logic                 r_pending;
    logic                 r_div_err;
    logic [OS_LOG2-1:0]   r_os_idx;
    logic                 r_bit_tick;

    logic       w_tx_wrap;
    logic       w_rx_wrap;
    logic       w_tx_tick;
    logic       w_rx_os_tick;
    logic       w_load_ok;
    logic       w_load_bad;
    logic       w_apply;
    logic       w_rx_clear;
    baud_tick_t w_ticks;

    assign w_load_bad = div_load && (div_in < MIN_DIV_W);
    assign w_load_ok  = div_load && !w_load_bad;
    // A stopped generator has no period to protect, so a pending value goes in at once.
    assign w_apply    = r_pending && (w_tx_wrap || !enable);
    assign w_rx_clear = rx_resync || w_apply;

    baud_div_counter #(.WIDTH(DIV_WIDTH)) u_tx_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .i_clear  (1'b0),
        .i_period (r_div_active),
        .o_wrap   (w_tx_wrap),
        .o_tick   (w_tx_tick)
    );

    baud_div_counter #(.WIDTH(DIV_WIDTH)) u_rx_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .i_clear  (w_rx_clear),
        .i_period (r_rx_period),
        .o_wrap   (w_rx_wrap),
        .o_tick   (w_rx_os_tick)
    );

    // Divisor shadow, apply and rejection flag; a coincident load lands after the apply.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_active <= RST_DIV;
            r_rx_period  <= RST_DIV >> OS_LOG2;
            r_shadow     <= RST_DIV;
            r_pending    <= 1'b0;
            r_div_err    <= 1'b0;
        end else begin
            r_div_err <= w_load_bad;
            if (w_apply) begin
                r_div_active <= r_shadow;
                r_rx_period  <= r_shadow >> OS_LOG2;
            end else begin
                r_div_active <= r_div_active;
                r_rx_period  <= r_rx_period;
            end
            if (w_load_ok) begin
                r_shadow  <= div_in;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

    // Oversample index follows the RX counter and restarts with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_os_idx   <= '0;
            r_bit_tick <= 1'b0;
        end else if (!enable || w_rx_clear) begin
            r_os_idx   <= '0;
            r_bit_tick <= 1'b0;
        end else if (w_rx_wrap) begin
            r_os_idx   <= r_os_idx + OS_LOG2'(1'b1);
            r_bit_tick <= (r_os_idx == IDX_MAX);
        end else begin
            r_bit_tick <= 1'b0;
        end
    end

    assign w_ticks     = '{tx: w_tx_tick, rx_os: w_rx_os_tick, rx_bit: r_bit_tick};
    assign tx_tick     = w_ticks.tx;
    assign rx_os_tick  = w_ticks.rx_os;
    assign rx_bit_tick = w_ticks.rx_bit;
    assign rx_os_idx   = r_os_idx;
    assign div_active  = r_div_active;
    assign div_pending = r_pending;
    assign div_err     = r_div_err;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: expected tick cycles are queued per stream
// and a negedge monitor pops and compares them whenever the DUT pulses a tick.
module tb_uart_baud_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        div_load;
    logic [15:0] div_in;
    logic        rx_resync;
    logic        tx_tick;
    logic        rx_os_tick;
    logic        rx_bit_tick;
    logic [3:0]  rx_os_idx;
    logic [15:0] div_active;
    logic        div_pending;
    logic        div_err;

    int cyc    = 0;
    int b      = 0;
    int n_chk  = 0;
    int n_pass = 0;
    int q_tx[$];
    int q_os[$];
    int q_bit[$];
    int q_err[$];

    uart_baud_gen dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .div_load    (div_load),
        .div_in      (div_in),
        .rx_resync   (rx_resync),
        .tx_tick     (tx_tick),
        .rx_os_tick  (rx_os_tick),
        .rx_bit_tick (rx_bit_tick),
        .rx_os_idx   (rx_os_idx),
        .div_active  (div_active),
        .div_pending (div_pending),
        .div_err     (div_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, cyc - b);
    endtask

    // Monitor: every tick must match the head of its expected-cycle queue.
    always @(negedge clk) begin
        if (tx_tick) begin
            if (q_tx.size() == 0) check("tx_tick_unexpected", cyc - b, -1);
            else check("tx_tick_cycle", cyc - b, q_tx.pop_front());
        end
        if (rx_os_tick) begin
            if (q_os.size() == 0) check("rx_os_tick_unexpected", cyc - b, -1);
            else check("rx_os_tick_cycle", cyc - b, q_os.pop_front());
        end
        if (rx_bit_tick) begin
            if (q_bit.size() == 0) check("rx_bit_tick_unexpected", cyc - b, -1);
            else check("rx_bit_tick_cycle", cyc - b, q_bit.pop_front());
        end
        if (div_err) begin
            if (q_err.size() == 0) check("div_err_unexpected", cyc - b, -1);
            else check("div_err_cycle", cyc - b, q_err.pop_front());
        end
    end

    task automatic wait_to(input int t);
        while (cyc - b < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_os(input int start, input int step, input int n);
        for (int j = 1; j <= n; j++) q_os.push_back(start + step * j);
    endtask

    task automatic check_div(input string name, input int act_exp, input int pend_exp);
        check({name, "_div_active"}, int'(div_active), act_exp);
        check({name, "_div_pending"}, int'(div_pending), pend_exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at t=%0d", cyc - b);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; div_load = 1'b0; div_in = 16'd0; rx_resync = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_tx_tick", int'(tx_tick), 0);
        check("rst_rx_os_tick", int'(rx_os_tick), 0);
        check("rst_rx_bit_tick", int'(rx_bit_tick), 0);
        check("rst_rx_os_idx", int'(rx_os_idx), 0);
        check("rst_div_err", int'(div_err), 0);
        check_div("rst", 1302, 0);

        // Defaults, then a 434 load mid-period applied at the 3906 wrap.
        b = cyc; reset = 1'b1; enable = 1'b1;
        q_tx.push_back(1302); q_tx.push_back(2604); q_tx.push_back(3906);
        q_tx.push_back(4340); q_tx.push_back(4774);
        expect_os(0, 81, 48);
        expect_os(3906, 27, 22);
        q_bit.push_back(1296); q_bit.push_back(2592); q_bit.push_back(3888); q_bit.push_back(4338);
        wait_to(2650);
        check_div("defaults", 1302, 0);
        div_load = 1'b1; div_in = 16'd434;
        wait_to(2651);
        div_load = 1'b0;
        check_div("load434_pending", 1302, 1);
        wait_to(3905);
        check_div("load434_before_wrap", 1302, 1);
        wait_to(3906);
        check_div("load434_applied", 434, 0);
        check("apply_rx_os_idx", int'(rx_os_idx), 0);

        // Rejected divisors 20 and 31 (just below the minimum of 32).
        q_err.push_back(4001); q_err.push_back(4011);
        wait_to(4000);
        div_load = 1'b1; div_in = 16'd20;
        wait_to(4001);
        div_load = 1'b0;
        wait_to(4010);
        div_load = 1'b1; div_in = 16'd31;
        wait_to(4011);
        div_load = 1'b0;
        wait_to(4015);
        check_div("rejected", 434, 0);

        // Resync on the very edge where an RX wrap would have fired.
        q_tx.push_back(5208); q_tx.push_back(5642);
        expect_os(4527, 27, 41);
        q_bit.push_back(4959); q_bit.push_back(5391);
        wait_to(4526);
        check("pre_resync_idx", int'(rx_os_idx), 6);
        rx_resync = 1'b1;
        wait_to(4527);
        rx_resync = 1'b0;
        check("resync_idx", int'(rx_os_idx), 0);
        check("resync_no_os_tick", int'(rx_os_tick), 0);

        // Loads coincident with TX wraps: 500 at 5208, 868 at 5642.
        expect_os(5642, 31, 16);
        q_bit.push_back(6138);
        q_tx.push_back(6142); q_tx.push_back(7010);
        expect_os(6142, 54, 17);
        q_bit.push_back(7006);
        wait_to(5207);
        div_load = 1'b1; div_in = 16'd500;
        wait_to(5208);
        div_load = 1'b0;
        check_div("coinc_not_applied", 434, 1);
        wait_to(5641);
        div_load = 1'b1; div_in = 16'd868;
        wait_to(5642);
        div_load = 1'b0;
        check_div("coinc_prev_applied", 500, 1);
        check("coinc_rx_os_idx", int'(rx_os_idx), 0);
        wait_to(6142);
        check_div("coinc_next_applied", 868, 0);

        // Enable low for 100 cycles.
        q_tx.push_back(8068);
        expect_os(7200, 54, 17);
        q_bit.push_back(8064);
        wait_to(7100);
        enable = 1'b0;
        wait_to(7150);
        check("disabled_idx", int'(rx_os_idx), 0);
        check_div("disabled", 868, 0);
        wait_to(7200);
        enable = 1'b1;

        // Reset with a load pending discards it.
        q_tx.push_back(9462);
        expect_os(8160, 81, 16);
        q_bit.push_back(9456);
        wait_to(8100);
        div_load = 1'b1; div_in = 16'd1000;
        wait_to(8101);
        div_load = 1'b0;
        check_div("pre_reset_pending", 868, 1);
        wait_to(8150);
        reset = 1'b0;
        wait_to(8151);
        check_div("mid_reset", 1302, 0);
        check("mid_reset_idx", int'(rx_os_idx), 0);
        wait_to(8160);
        reset = 1'b1;
        wait_to(9463);
        check_div("post_reset", 1302, 0);
        wait_to(9500);

        check("tx_leftover", q_tx.size(), 0);
        check("rx_os_leftover", q_os.size(), 0);
        check("rx_bit_leftover", q_bit.size(), 0);
        check("div_err_leftover", q_err.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
